// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I lab datapath: fetch, decode, execute,
// data-memory access and write-back sequencing, with a sticky trap and retire counter.
module rv_multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               alu_zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               ir_load,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               alu_src,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               pc_write,
    output logic               pc_src,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] instret
);

    // state  | meaning
    // FETCH  | request instruction, load IR on ack
    // DECODE | classify opcode/funct3
    // EXEC   | drive ALU controls; branches retire here
    // MEM    | data-memory access; stores retire on ack
    // WB     | register write-back, retire
    // TRAP   | unsupported instruction, wait for reset
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // beq/bne are split into separate classes so funct3 is only needed in DECODE
    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_BNE
    } class_t;

    state_t             st_q;
    class_t             cls_q;
    class_t             cls_d;
    logic               valid_d;
    logic               illegal_q;
    logic [COUNT_W-1:0] cnt_q;

    always_comb begin
        cls_d   = C_R;
        valid_d = 1'b1;
        case (opcode)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: begin
                if (funct3 == 3'b000)      cls_d = C_BEQ;
                else if (funct3 == 3'b001) cls_d = C_BNE;
                else                       valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= FETCH;
            cls_q     <= C_R;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (pc_write) cnt_q <= cnt_q + COUNT_W'(1);
            case (st_q)
                FETCH:  if (imem_ack) st_q <= DECODE;
                DECODE: begin
                    if (valid_d) begin
                        cls_q <= cls_d;
                        st_q  <= EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        st_q      <= TRAP;
                    end
                end
                EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: st_q <= MEM;
                        C_BEQ, C_BNE:    st_q <= FETCH;
                        default:         st_q <= WB;
                    endcase
                end
                MEM:    if (dmem_ack) st_q <= (cls_q == C_STORE) ? FETCH : WB;
                WB:     st_q <= FETCH;
                TRAP:   st_q <= TRAP;
                default: st_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        if (!reset) begin
            case (st_q)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                EXEC: begin
                    case (cls_q)
                        C_R: alu_op = 2'b10;
                        C_I: begin
                            alu_src = 1'b1;
                            alu_op  = 2'b11;
                        end
                        C_LOAD, C_STORE: alu_src = 1'b1;
                        C_BEQ, C_BNE: begin
                            alu_op   = 2'b01;
                            pc_write = 1'b1;
                            pc_src   = (cls_q == C_BEQ) ? alu_zero : !alu_zero;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == C_STORE);
                    pc_write = dmem_ack && (cls_q == C_STORE);
                end
                WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == C_LOAD);
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q && !reset;
    assign state   = reset ? 3'd0 : st_q;
    assign instret = reset ? '0 : cnt_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I lab datapath. It sequences instruction fetch, loading of the instruction register that feeds the instruction field parser, decode, execute, data-memory access and write-back. It consumes the parsed `opcode`/`funct3` fields and an ALU zero flag, and drives every datapath strobe and memory request. Supported classes: R-type ALU, I-type ALU, load, store, and branch (beq/bne only). Anything else traps.

## Interface

Parameters:
- `COUNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction[6:0] from the parser (IR-driven, stable after `ir_load`).
- `funct3`  in  3  instruction[14:12] from the parser.
- `alu_zero`  in  1  ALU result == 0.
- `imem_ack`  in  1  instruction memory has valid data this cycle.
- `dmem_ack`  in  1  data memory access completes this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_load`  out  1  capture instruction memory data into IR.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `alu_src`  out  1  0 = rs2, 1 = immediate.
- `alu_op`  out  2  00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
- `reg_write`  out  1  register file write enable.
- `mem_to_reg`  out  1  write-back source is memory.
- `pc_write`  out  1  update PC (one instruction retires).
- `pc_src`  out  1  0 = PC+4, 1 = branch target.
- `illegal`  out  1  sticky trap flag.
- `state`  out  3  current state, for debug.
- `instret`  out  COUNT_W  retired-instruction count.

## Operation

- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and recover to FETCH.
- FETCH: `imem_req`=1 and is held until `imem_ack`. In the ack cycle, `ir_load`=1 and the next state is DECODE. Without ack, stay in FETCH.
- DECODE: latch the instruction class from `opcode`/`funct3` into an internal register.
  - 0110011 → R.
  - 0010011 → I.
  - 0000011 → LOAD.
  - 0100011 → STORE.
  - 1100011 with funct3 000/001 → BRANCH.
  - Otherwise → TRAP.
  - Valid classes go to EXEC.
- EXEC:
  - R: `alu_src`=0, `alu_op`=10; go to WB.
  - I: `alu_src`=1, `alu_op`=11; go to WB.
  - LOAD/STORE: `alu_src`=1, `alu_op`=00; go to MEM.
  - BRANCH: `alu_src`=0, `alu_op`=01, `pc_write`=1, and `pc_src` = (funct3==000 ? `alu_zero` : !`alu_zero`); go to FETCH.
- MEM: `dmem_req`=1, and `dmem_we`=1 for STORE; both are held until `dmem_ack`.
  - STORE ack cycle: `pc_write`=1, `pc_src`=0; go to FETCH.
  - LOAD ack cycle: go to WB.
- WB: `reg_write`=1, `mem_to_reg`=1 for LOAD (0 otherwise), `pc_write`=1, `pc_src`=0; go to FETCH.
- TRAP: `illegal`=1. All other strobes are 0. The FSM stays in TRAP until `reset`; `instret` is frozen.
- `instret` increments by 1 on every cycle with `pc_write`=1 and wraps from 2^COUNT_W−1 to 0.
- Outputs not listed for a state are 0.

## Timing

- Outputs are combinational from the registered state, the latched class, and same-cycle `imem_ack`/`dmem_ack`/`alu_zero`. `instret` and `illegal` are registered.
- While `reset`=1, all outputs are forced to 0.
- At the first edge with `reset`=1:
  - state=FETCH.
  - `instret`=0.
  - `illegal`=0.
  - class=R.
- The first `imem_req` appears in the first cycle after `reset` deasserts.
- Reset mid-operation (including mid-MEM or in TRAP) aborts the instruction with no `pc_write`. Requests drop in the reset cycle.
- Acks sampled outside their request state are ignored.
- Cycles per instruction with zero-wait acks (ack in the request cycle):
  - R/I: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each wait cycle on an ack adds 1 cycle.
- `opcode`/`funct3` are sampled only in DECODE. Changes in other states have no effect.

## Test plan

- Reset held 3 cycles, then released, with `imem_ack`=1 and opcode 0110011 → `state` sequence 0,1,2,4,0; `reg_write`=1 and `pc_write`=1 only in WB; `instret`=1 after WB.
- LOAD (0000011) with `dmem_ack` delayed 2 cycles → MEM for 3 cycles with `dmem_req`=1 and `dmem_we`=0; WB has `mem_to_reg`=1; total 7 cycles.
- STORE (0100011) → MEM `dmem_we`=1; no `reg_write` anywhere; `pc_write` in the MEM ack cycle; `instret`+1.
- beq with `alu_zero`=1 → EXEC `pc_src`=1; bne with `alu_zero`=1 → `pc_src`=0; both return to FETCH after 3 cycles.
- Opcode 1111111, then branch with funct3 010 after reset → TRAP, `illegal`=1 held for 20 cycles with no strobes; `reset` clears `illegal` and the FSM refetches.
- COUNT_W=4 with 17 back-to-back R-type instructions → `instret` wraps 15→0 and ends at 1; `reset` asserted during a MEM wait → `dmem_req` is 0 in that cycle and `instret` is 0 afterwards.
